// File: rtl/cam_pkg.sv
// Shared encodings for the associative lookup table: request opcodes and
// controller states.
package cam_pkg;

  typedef enum logic [1:0] {
    CAM_OP_SEARCH     = 2'b00,
    CAM_OP_INSERT     = 2'b01,
    CAM_OP_INVALIDATE = 2'b10,
    CAM_OP_FLUSH      = 2'b11
  } cam_op_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_FLUSHING = 1'b1
  } cam_state_e;

endpackage

// File: rtl/assoc_cam_param_if.sv
// Request/response bundle of the associative lookup table, plus its
// occupancy status.
interface assoc_cam_param_if #(
  parameter int KEY_W  = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              REQ_VALID;
  logic              REQ_READY;
  logic [1:0]        REQ_OP;
  logic [KEY_W-1:0]  REQ_KEY;
  logic [DATA_W-1:0] REQ_DATA;
  logic              RSP_VALID;
  logic              RSP_HIT;
  logic [IDX_W-1:0]  RSP_INDEX;
  logic [DATA_W-1:0] RSP_DATA;
  logic [IDX_W:0]    OCCUPANCY;
  logic              FULL;

  modport master (
    output REQ_VALID, REQ_OP, REQ_KEY, REQ_DATA,
    input  REQ_READY, RSP_VALID, RSP_HIT, RSP_INDEX, RSP_DATA, OCCUPANCY, FULL
  );

  modport slave (
    input  REQ_VALID, REQ_OP, REQ_KEY, REQ_DATA,
    output REQ_READY, RSP_VALID, RSP_HIT, RSP_INDEX, RSP_DATA, OCCUPANCY, FULL
  );

endinterface

// File: rtl/cam_priority_enc.sv
// Lowest-index priority encoder: reports whether any bit is set and the
// index of the lowest set bit (0 when none).
module cam_priority_enc #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         vec,
  output logic                     any,
  output logic [$clog2(DEPTH)-1:0] idx
);
  localparam int IDX_W = $clog2(DEPTH);

  // Scan downward so the lowest set bit is the last one assigned.
  always_comb begin
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/assoc_cam_param.sv
// Parametrised content-addressable lookup table with valid bits, priority
// match, insert-with-update, round-robin replacement and multi-cycle flush.
module assoc_cam_param
  import cam_pkg::*;
#(
  parameter int KEY_W  = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input logic              CLK,
  input logic              RESET,
  assoc_cam_param_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  function automatic logic [OCC_W-1:0] occ_inc(input logic [OCC_W-1:0] occ);
    return (occ == OCC_W'(DEPTH)) ? occ : occ + 1'b1;
  endfunction

  function automatic logic [OCC_W-1:0] occ_dec(input logic [OCC_W-1:0] occ);
    return (occ == '0) ? occ : occ - 1'b1;
  endfunction

  cam_state_e        state_q, state_d;
  logic [DEPTH-1:0]  valid_q;
  logic [KEY_W-1:0]  key_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [OCC_W-1:0]  occ_q;
  logic [IDX_W-1:0]  rptr_q;
  logic [IDX_W-1:0]  fcnt_q;

  cam_op_e           op_p0;
  logic              accept_p0;
  logic              ready_p0;
  logic              flush_last_p0;
  logic [DEPTH-1:0]  match_vec_p0;
  logic              hit_any_p0, free_any_p0;
  logic [IDX_W-1:0]  hit_idx_p0, free_idx_p0, wr_idx_p0;

  logic              rsp_vld_p1;
  logic              rsp_hit_p1;
  logic [IDX_W-1:0]  rsp_idx_p1;
  logic [DATA_W-1:0] rsp_data_p1;

  // ---- Stage p0: request decode and lookup ----
  assign op_p0         = cam_op_e'(bus.REQ_OP);
  assign accept_p0     = bus.REQ_VALID && (state_q == ST_IDLE);
  assign flush_last_p0 = (state_q == ST_FLUSHING) && (fcnt_q == IDX_W'(DEPTH - 1));

  always_comb begin
    match_vec_p0 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec_p0[i] = valid_q[i] && (key_q[i] == bus.REQ_KEY);
    end
  end

  cam_priority_enc #(.DEPTH(DEPTH)) u_match_enc (
    .vec (match_vec_p0),
    .any (hit_any_p0),
    .idx (hit_idx_p0)
  );

  cam_priority_enc #(.DEPTH(DEPTH)) u_free_enc (
    .vec (~valid_q),
    .any (free_any_p0),
    .idx (free_idx_p0)
  );

  // Update in place on hit, else lowest free slot, else the replacement victim.
  assign wr_idx_p0 = hit_any_p0  ? hit_idx_p0  :
                     free_any_p0 ? free_idx_p0 : rptr_q;

  always_comb begin
    state_d  = state_q;
    ready_p0 = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_p0 = 1'b1;
        if (accept_p0 && op_p0 == CAM_OP_FLUSH) state_d = ST_FLUSHING;
      end
      ST_FLUSHING: begin
        if (flush_last_p0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (accept_p0 && op_p0 == CAM_OP_INSERT) begin
      key_q[wr_idx_p0]  <= bus.REQ_KEY;
      data_q[wr_idx_p0] <= bus.REQ_DATA;
    end
  end

  // ---- Stage p1: registered response and control state ----
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q     <= '0;
      occ_q       <= '0;
      rptr_q      <= '0;
      fcnt_q      <= '0;
      rsp_vld_p1  <= 1'b0;
      rsp_hit_p1  <= 1'b0;
      rsp_idx_p1  <= '0;
      rsp_data_p1 <= '0;
    end else begin
      rsp_vld_p1  <= 1'b0;
      rsp_hit_p1  <= 1'b0;
      rsp_idx_p1  <= '0;
      rsp_data_p1 <= '0;
      if (accept_p0) begin
        rsp_vld_p1 <= (op_p0 != CAM_OP_FLUSH);
        case (op_p0)
          CAM_OP_SEARCH: begin
            rsp_hit_p1 <= hit_any_p0;
            if (hit_any_p0) begin
              rsp_idx_p1  <= hit_idx_p0;
              rsp_data_p1 <= data_q[hit_idx_p0];
            end
          end
          CAM_OP_INSERT: begin
            rsp_hit_p1 <= hit_any_p0;
            rsp_idx_p1 <= wr_idx_p0;
            if (!hit_any_p0) begin
              if (free_any_p0) begin
                valid_q[free_idx_p0] <= 1'b1;
                occ_q                <= occ_inc(occ_q);
              end else begin
                rptr_q <= rptr_q + 1'b1;
              end
            end
          end
          CAM_OP_INVALIDATE: begin
            rsp_hit_p1 <= hit_any_p0;
            if (hit_any_p0) begin
              rsp_idx_p1          <= hit_idx_p0;
              valid_q[hit_idx_p0] <= 1'b0;
              occ_q               <= occ_dec(occ_q);
            end
          end
          CAM_OP_FLUSH: begin
            fcnt_q <= '0;
          end
          default: ;
        endcase
      end else if (state_q == ST_FLUSHING) begin
        valid_q[fcnt_q] <= 1'b0;
        fcnt_q          <= fcnt_q + 1'b1;
        if (flush_last_p0) begin
          occ_q      <= '0;
          rptr_q     <= '0;
          rsp_vld_p1 <= 1'b1;
          rsp_idx_p1 <= IDX_W'(DEPTH - 1);
        end
      end
    end
  end

  assign bus.REQ_READY = ready_p0;
  assign bus.RSP_VALID = rsp_vld_p1;
  assign bus.RSP_HIT   = rsp_hit_p1;
  assign bus.RSP_INDEX = rsp_idx_p1;
  assign bus.RSP_DATA  = rsp_data_p1;
  assign bus.OCCUPANCY = occ_q;
  assign bus.FULL      = (occ_q == OCC_W'(DEPTH));

endmodule

// File: tb/tb_assoc_cam_param.sv
// Directed plus randomized bench for assoc_cam_param (DEPTH=4) against a
// behavioural table model.
module tb_assoc_cam_param;
  localparam int D = 4;
  localparam logic [1:0] OP_S = 2'b00, OP_I = 2'b01, OP_V = 2'b10, OP_F = 2'b11;

  logic CLK;
  logic RESET;

  assoc_cam_param_if #(.KEY_W(8), .DATA_W(8), .DEPTH(D)) bus ();

  assoc_cam_param #(.KEY_W(8), .DATA_W(8), .DEPTH(D)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;

  bit         mval  [D];
  logic [7:0] mkey  [D];
  logic [7:0] mdata [D];
  int         mocc;
  int         mptr;

  logic       o_hit;
  logic [1:0] o_idx;
  logic [7:0] o_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) mval[i] = 1'b0;
    mocc = 0;
    mptr = 0;
  endtask

  // Table semantics: lowest matching valid entry wins; inserts fill the
  // lowest free slot, or evict round-robin when the table is full.
  task automatic model_op(input logic [1:0] op, input logic [7:0] k, input logic [7:0] d,
                          output logic eh, output logic [1:0] ei, output logic [7:0] ed);
    int m;
    int f;
    m = -1;
    f = -1;
    for (int i = 0; i < D; i++) if (m < 0 && mval[i] && mkey[i] == k) m = i;
    for (int i = 0; i < D; i++) if (f < 0 && !mval[i]) f = i;
    eh = (m >= 0);
    ei = 2'd0;
    ed = 8'd0;
    case (op)
      OP_S: if (m >= 0) begin
        ei = 2'(m);
        ed = mdata[m];
      end
      OP_I: begin
        if (m >= 0) begin
          mdata[m] = d;
          ei = 2'(m);
        end else if (f >= 0) begin
          mval[f] = 1'b1; mkey[f] = k; mdata[f] = d;
          mocc++;
          ei = 2'(f);
        end else begin
          mkey[mptr] = k; mdata[mptr] = d;
          ei = 2'(mptr);
          mptr = (mptr + 1) % D;
        end
      end
      OP_V: if (m >= 0) begin
        mval[m] = 1'b0;
        mocc--;
        ei = 2'(m);
      end
      default: ;
    endcase
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge CLK);
    while (bus.REQ_READY !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("ready_before_req", 32'(bus.REQ_READY), 32'd1);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [7:0] k, input logic [7:0] d);
    logic       eh;
    logic [1:0] ei;
    logic [7:0] ed;
    wait_ready();
    bus.REQ_VALID = 1'b1;
    bus.REQ_OP    = op;
    bus.REQ_KEY   = k;
    bus.REQ_DATA  = d;
    @(posedge CLK);
    #1;
    bus.REQ_VALID = 1'b0;
    model_op(op, k, d, eh, ei, ed);
    o_hit  = bus.RSP_HIT;
    o_idx  = bus.RSP_INDEX;
    o_data = bus.RSP_DATA;
    check("rsp_valid", 32'(bus.RSP_VALID), 32'd1);
    check("rsp_hit",   32'(bus.RSP_HIT),   32'(eh));
    check("rsp_index", 32'(bus.RSP_INDEX), 32'(ei));
    check("rsp_data",  32'(bus.RSP_DATA),  32'(ed));
    check("occupancy", 32'(bus.OCCUPANCY), 32'(mocc));
    check("full",      32'(bus.FULL),      32'(mocc == D));
  endtask

  task automatic do_flush();
    int n;
    int early;
    wait_ready();
    bus.REQ_VALID = 1'b1;
    bus.REQ_OP    = OP_F;
    bus.REQ_KEY   = 8'h00;
    bus.REQ_DATA  = 8'h00;
    @(posedge CLK);
    #1;
    bus.REQ_VALID = 1'b0;
    n = 0;
    early = 0;
    while (bus.REQ_READY === 1'b0 && n < 20) begin
      if (bus.RSP_VALID === 1'b1) early++;
      n++;
      @(posedge CLK);
      #1;
    end
    model_clear();
    check("flush_busy_cycles", 32'(n), 32'(D));
    check("flush_early_rsp",   32'(early), 32'd0);
    check("flush_rsp_valid",   32'(bus.RSP_VALID), 32'd1);
    check("flush_rsp_hit",     32'(bus.RSP_HIT), 32'd0);
    check("flush_rsp_index",   32'(bus.RSP_INDEX), 32'(D - 1));
    check("flush_occupancy",   32'(bus.OCCUPANCY), 32'd0);
    check("flush_full",        32'(bus.FULL), 32'd0);
    @(posedge CLK);
    #1;
    check("flush_rsp_one_pulse", 32'(bus.RSP_VALID), 32'd0);
  endtask

  initial begin
    int r;
    RESET         = 1'b1;
    bus.REQ_VALID = 1'b0;
    bus.REQ_OP    = OP_S;
    bus.REQ_KEY   = 8'h00;
    bus.REQ_DATA  = 8'h00;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    check("reset_occupancy", 32'(bus.OCCUPANCY), 32'd0);
    check("reset_full",      32'(bus.FULL), 32'd0);
    check("reset_ready",     32'(bus.REQ_READY), 32'd1);
    @(negedge CLK);
    RESET = 1'b0;

    do_req(OP_S, 8'h00, 8'h00);
    check("search0_hit", 32'(o_hit), 32'd0);
    check("search0_data", 32'(o_data), 32'd0);

    do_req(OP_I, 8'h11, 8'hA1);
    check("ins11_idx", 32'(o_idx), 32'd0);
    do_req(OP_I, 8'h22, 8'hB2);
    check("ins22_idx", 32'(o_idx), 32'd1);
    check("occ_after_two", 32'(bus.OCCUPANCY), 32'd2);
    do_req(OP_S, 8'h22, 8'h00);
    check("srch22_data", 32'(o_data), 32'hB2);

    do_req(OP_I, 8'h11, 8'hC3);
    check("upd11_hit", 32'(o_hit), 32'd1);
    check("upd11_idx", 32'(o_idx), 32'd0);
    do_req(OP_S, 8'h11, 8'h00);
    check("srch11_data", 32'(o_data), 32'hC3);

    do_req(OP_V, 8'h11, 8'h00);
    check("inv11_hit", 32'(o_hit), 32'd1);
    check("occ_after_inv", 32'(bus.OCCUPANCY), 32'd1);
    do_req(OP_I, 8'h33, 8'h03);
    check("ins33_idx", 32'(o_idx), 32'd0);
    do_req(OP_I, 8'h44, 8'h04);
    check("ins44_idx", 32'(o_idx), 32'd2);
    do_req(OP_I, 8'h55, 8'h05);
    check("ins55_idx", 32'(o_idx), 32'd3);
    check("full_after_55", 32'(bus.FULL), 32'd1);
    do_req(OP_I, 8'h66, 8'h06);
    check("repl66_idx", 32'(o_idx), 32'd0);
    do_req(OP_I, 8'h77, 8'h07);
    check("repl77_idx", 32'(o_idx), 32'd1);
    do_req(OP_S, 8'h33, 8'h00);
    check("srch33_evicted", 32'(o_hit), 32'd0);

    do_flush();
    do_req(OP_I, 8'h88, 8'h08);
    check("post_flush_idx", 32'(o_idx), 32'd0);
    do_req(OP_I, 8'h99, 8'h09);

    // Reset lands in the second flushing cycle.
    wait_ready();
    bus.REQ_VALID = 1'b1;
    bus.REQ_OP    = OP_F;
    @(posedge CLK);
    #1;
    bus.REQ_VALID = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    check("midflush_ready", 32'(bus.REQ_READY), 32'd1);
    check("midflush_occ", 32'(bus.OCCUPANCY), 32'd0);
    check("midflush_rsp", 32'(bus.RSP_VALID), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    model_clear();
    for (int i = 0; i < D + 2; i++) begin
      @(posedge CLK);
      #1;
      check("midflush_no_pulse", 32'(bus.RSP_VALID), 32'd0);
    end
    do_req(OP_S, 8'h88, 8'h00);
    check("midflush_key_gone", 32'(o_hit), 32'd0);

    for (int it = 0; it < 250; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 35)      do_req(OP_S, 8'($urandom_range(0, 7)), 8'h00);
      else if (r < 75) do_req(OP_I, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      else if (r < 96) do_req(OP_V, 8'($urandom_range(0, 7)), 8'h00);
      else             do_flush();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/assoc_cam_param.md
Name: assoc_cam_param

Overview:
- Parametrised content-addressable memory: the successor to the fixed 8-entry associative store in the memory unit.
- Adds valid bits, hit/miss/index reporting, and lowest-index priority match.
- Adds insert-with-update, round-robin replacement when full, invalidate, multi-cycle flush and an occupancy count.
- Sits beside primary memory as a lookup table (TLB/tag-store style), driven by a request/response handshake.

Parameters:
KEY_W, 8, key width in bits
DATA_W, 8, associated data width in bits
DEPTH, 8, number of entries (power of two, >=2)
IDX_W, $clog2(DEPTH), index width (derived, do not override)

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  asynchronous, active-high reset
REQ_VALID  input  1  request present
REQ_READY  output  1  block accepts request this cycle
REQ_OP  input  2  00 SEARCH, 01 INSERT, 10 INVALIDATE, 11 FLUSH
REQ_KEY  input  KEY_W  key for SEARCH/INSERT/INVALIDATE
REQ_DATA  input  DATA_W  data for INSERT
RSP_VALID  output  1  one-cycle response pulse
RSP_HIT  output  1  key matched a valid entry
RSP_INDEX  output  IDX_W  matched or written entry
RSP_DATA  output  DATA_W  data of matched entry (SEARCH), else 0
OCCUPANCY  output  IDX_W+1  count of valid entries
FULL  output  1  OCCUPANCY==DEPTH (combinational from count)

Behaviour:
- Reset: all valid bits 0, OCCUPANCY 0, replacement pointer 0, FSM IDLE, RSP_* 0. Key/data arrays are not reset. Reset asserted mid-flush aborts the flush at once, with the same result.
- Accept: REQ_VALID && REQ_READY. REQ_READY=1 in IDLE, 0 in FLUSHING; requests are ignored while RESET is high.
- Timing: lookup and array update happen at the accepting edge. The response is registered: RSP_VALID is high exactly one cycle after acceptance. The response has no backpressure.
- Back-to-back: one request per cycle; each request sees the effects of all earlier accepted requests.
- Match: valid[i] && key[i]==REQ_KEY. On multiple matches the lowest index wins.
- SEARCH:
  - hit: RSP_HIT=1, RSP_INDEX=i, RSP_DATA=data[i]
  - miss: RSP_HIT=0, RSP_INDEX=0, RSP_DATA=0
- INSERT:
  - hit: data[i] overwritten, RSP_HIT=1, RSP_INDEX=i, occupancy unchanged.
  - miss, not full: write the lowest-index free entry, set valid, occupancy +1, RSP_HIT=0.
  - miss, full: overwrite the entry at the replacement pointer, then pointer = (pointer+1) mod DEPTH. Occupancy unchanged, RSP_HIT=0.
  - RSP_INDEX is always the entry written.
- INVALIDATE:
  - hit: valid[i]=0, occupancy -1, RSP_HIT=1, RSP_INDEX=i.
  - miss: no state change, RSP_HIT=0.
- FLUSH:
  - FSM IDLE->FLUSHING at the accepting edge; internal counter starts at 0.
  - Each FLUSHING cycle clears valid[counter] and increments the counter; after clearing entry DEPTH-1, return to IDLE.
  - REQ_READY is low for exactly DEPTH cycles.
  - On the final clear edge: OCCUPANCY=0, replacement pointer=0, RSP_VALID pulses with RSP_HIT=0 and RSP_INDEX=DEPTH-1.
- Occupancy never exceeds DEPTH or underflows. FULL follows OCCUPANCY combinationally.
- SEARCH, INSERT-hit and INVALIDATE do not move the replacement pointer.

Decomposition:
- Shared package cam_pkg: op encodings (CAM_OP_SEARCH/INSERT/INVALIDATE/FLUSH) and FSM state constants (ST_IDLE, ST_FLUSHING).
- One sub-module, cam_priority_enc, parametrised by DEPTH: takes a DEPTH-bit vector and outputs any-set plus lowest set index. Instantiated twice: match vector and free (~valid) vector.

Test Plan:
- Reset, DEPTH=4: check OCCUPANCY=0, FULL=0, REQ_READY=1 and SEARCH key 0x00 -> RSP_HIT=0, RSP_DATA=0.
- Fill and hit:
  - INSERT (0x11,0xA1), (0x22,0xB2) -> RSP_INDEX 0 then 1, RSP_HIT=0, OCCUPANCY=2.
  - SEARCH 0x22 next cycle -> RSP_HIT=1, RSP_INDEX=1, RSP_DATA=0xB2.
- Update: INSERT (0x11,0xC3) -> RSP_HIT=1, RSP_INDEX=0, OCCUPANCY still 2. SEARCH 0x11 -> RSP_DATA=0xC3.
- Free-slot reuse, full and replacement:
  - INVALIDATE 0x11 -> RSP_HIT=1, RSP_INDEX=0, OCCUPANCY=1.
  - INSERT 0x33 -> index 0. INSERT 0x44, 0x55 -> indices 2 and 3; FULL=1.
  - INSERT 0x66 -> RSP_HIT=0, RSP_INDEX=0 (pointer 0->1). INSERT 0x77 -> RSP_INDEX=1.
  - SEARCH 0x33 -> RSP_HIT=0.
- Flush:
  - FLUSH when full -> REQ_READY low 4 cycles; RSP_VALID one pulse at end with RSP_HIT=0; OCCUPANCY=0.
  - Next INSERT -> RSP_INDEX=0.
- Reset mid-flush: assert RESET in the 2nd FLUSHING cycle -> REQ_READY=1 after release, OCCUPANCY=0, no RSP_VALID pulse, SEARCH of a prior key misses.
